game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the minesweeper core. Owns the screen state consumed by the sweep, map generator and display blocks.
- Gates the centre-button press into the sweep datapath and waits for the flood-fill reveal to settle before accepting another press.
- After each settled press it judges fail (a revealed mine) or victory (all safe cells revealed).
- Maintains the flags-left counter and the elapsed-seconds counter.

Parameters:
- MAP_W, 8, map width in cells
- MAP_H, 8, map height in cells
- CELL_LEN, 4, bits per cell code in map_i
- MINE_CODE, 4'hF, cell code that marks a mine
- MINE_NUM, 10, number of mines on the map
- SETTLE_MAX, 64, maximum cycles to wait for the reveal to settle
- CLK_PER_SEC, 50_000_000, clock cycles per timer second

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start_button_i  in  1  one-cycle pulse: start a new game
- mid_button_i  in  1  one-cycle pulse: sweep/flag press from the debouncer
- map_ready_i  in  1  level: map generator has a valid map
- map_i  in  CELL_LEN*MAP_W*MAP_H  full cell-code map
- map_shown_i  in  MAP_W*MAP_H  revealed-cell vector from the sweep block
- map_flag_i  in  MAP_W*MAP_H  flag vector from the sweep block
- screen_state_o  out  3  GAME_START / GAME_PLAY / GAME_VICTORY / GAME_FAIL codes from the project parameter header
- mid_button_o  out  1  gated press pulse to the sweep block
- busy_o  out  1  high while a press is being resolved
- flags_left_o  out  8  signed: MINE_NUM minus the number of flags
- time_sec_o  out  10  elapsed seconds in the current game

Behaviour:
- Clocking and reset: single clock domain (clk). Reset is synchronous and active-low (rst_n); all state updates on posedge clk.
- Reset values: FSM = IDLE, screen_state_o = GAME_START, busy_o = 0, flags_left_o = MINE_NUM, time_sec_o = 0, all internal counters = 0, shown-history register = 0.
- A reset asserted mid-game forces IDLE on the next edge, regardless of state.
- FSM states and screen_state_o mapping:
  - IDLE and GEN drive GAME_START.
  - WAIT, SETTLE and CHECK drive GAME_PLAY.
  - WIN drives GAME_VICTORY.
  - LOSE drives GAME_FAIL.
- IDLE: start_button_i goes to GEN.
- GEN: stays while map_ready_i = 0; map_ready_i = 1 goes to WAIT.
- WAIT:
  - mid_button_o = mid_button_i, combinational, zero latency, asserted only in this state.
  - A press goes to SETTLE and loads the settle counter with 0.
- SETTLE:
  - busy_o = 1.
  - Each cycle, register map_shown_i and compare it with the previous cycle's value.
  - Settled = two consecutive equal comparisons, or the settle counter reaching SETTLE_MAX - 1 (timeout). Either goes to CHECK.
- CHECK (one cycle, busy_o = 1), priority in this order:
  - lose = any cell with map_shown_i = 1 and code == MINE_CODE.
  - win = popcount(map_shown_i) == MAP_W*MAP_H - MINE_NUM.
  - Next state: lose goes to LOSE; else win goes to WIN; else WAIT.
- WIN / LOSE: start_button_i goes directly to GEN (new game). Presses are ignored.
- Presses in GEN, SETTLE or CHECK are dropped, never queued; mid_button_o stays 0.
- start_button_i in WAIT, SETTLE or CHECK is ignored.
- flags_left_o:
  - Registered each cycle to MINE_NUM - popcount(map_flag_i), one-cycle latency.
  - Two's complement; goes negative when flags exceed mines.
- time_sec_o:
  - Prescaler counts 0..CLK_PER_SEC-1 while in WAIT, SETTLE or CHECK.
  - On wrap, time_sec_o increments, saturating at 999.
  - Prescaler and seconds are cleared in IDLE and GEN, and frozen (held) in WIN and LOSE.
- Popcounts are sized ceil(log2(MAP_W*MAP_H+1)) bits.
- The mine scan is a parallel compare across all cells, registered only through the FSM.

Test Plan:
- Reset, then start_button_i, then map_ready_i = 1 one cycle later → screen GAME_START for 2 cycles, then GAME_PLAY; time_sec_o = 0; flags_left_o = 10.
- In WAIT, press with map_shown_i changing for 5 cycles then stable → mid_button_o pulses in the same cycle; busy_o high for exactly 5 + 2 + 1 cycles; a second press during busy gives mid_button_o = 0 and the FSM returns to WAIT.
- After a press, map_shown_i reveals a cell whose code = 4'hF → screen GAME_FAIL on the cycle after CHECK; time_sec_o frozen; later presses ignored; start_button_i re-enters GAME_START.
- Drive map_shown_i with 54 ones, none of them mines → GAME_VICTORY. Same vector plus one mine cell → GAME_FAIL (fail wins the tie).
- map_shown_i toggling every cycle after a press → CHECK entered after SETTLE_MAX = 64 cycles (timeout path).
- CLK_PER_SEC = 4, play for 4100 cycles → time_sec_o saturates at 999. Set 12 flag bits → flags_left_o = -2 (8'hFE) one cycle later. Reset asserted mid-SETTLE → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Minesweeper game sequencer: start/generate/play flow, press gating with reveal settling,
// fail/victory judgement, flags-left and elapsed-seconds counters.
module game_flow_ctrl #(
  parameter int unsigned         MAP_W       = 8,
  parameter int unsigned         MAP_H       = 8,
  parameter int unsigned         CELL_LEN    = 4,
  parameter logic [CELL_LEN-1:0] MINE_CODE   = 4'hF,
  parameter int unsigned         MINE_NUM    = 10,
  parameter int unsigned         SETTLE_MAX  = 64,
  parameter int unsigned         CLK_PER_SEC = 50_000_000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_button_i,
  input  logic                               mid_button_i,
  input  logic                               map_ready_i,
  input  logic [CELL_LEN*MAP_W*MAP_H-1:0]    map_i,
  input  logic [MAP_W*MAP_H-1:0]             map_shown_i,
  input  logic [MAP_W*MAP_H-1:0]             map_flag_i,
  output logic [2:0]                         screen_state_o,
  output logic                               mid_button_o,
  output logic                               busy_o,
  output logic [7:0]                         flags_left_o,
  output logic [9:0]                         time_sec_o
);

  localparam int unsigned Cells = MAP_W * MAP_H;
  localparam int unsigned PopW  = $clog2(Cells + 1);
  localparam int unsigned SetW  = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
  localparam int unsigned PscW  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  localparam logic [PopW-1:0] SafeCells  = PopW'(Cells - MINE_NUM);
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_MAX - 1);
  localparam logic [PscW-1:0] PscLast    = PscW'(CLK_PER_SEC - 1);
  localparam logic [9:0]      SecMax     = 10'd999;

  localparam logic [2:0] GAME_START   = 3'd0;
  localparam logic [2:0] GAME_PLAY    = 3'd1;
  localparam logic [2:0] GAME_VICTORY = 3'd2;
  localparam logic [2:0] GAME_FAIL    = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StWait,
    StSettle,
    StCheck,
    StWin,
    StLose
  } state_t;

  state_t state_q, state_d;

  logic [Cells-1:0] shown_q;
  logic             eq_prev_q;
  logic [SetW-1:0]  settle_cnt_q;
  logic [7:0]       flags_q;
  logic [PscW-1:0]  presc_q;
  logic [9:0]       sec_q;

  logic [Cells-1:0] mine_mask;
  logic             shown_eq;
  logic             settled;
  logic             lose;
  logic             win;
  logic             timer_run;
  logic             timer_clr;

  function automatic logic [PopW-1:0] popcount(input logic [Cells-1:0] v);
    logic [PopW-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < Cells; i++) begin
      sum = sum + PopW'(v[i]);
    end
    return sum;
  endfunction

  // Parallel mine scan over every cell code.
  always_comb begin
    mine_mask = '0;
    for (int unsigned i = 0; i < Cells; i++) begin
      mine_mask[i] = (map_i[i*CELL_LEN +: CELL_LEN] == MINE_CODE);
    end
  end

  assign lose     = |(mine_mask & map_shown_i);
  assign win      = (popcount(map_shown_i) == SafeCells);
  assign shown_eq = (map_shown_i == shown_q);
  assign settled  = (shown_eq && eq_prev_q) || (settle_cnt_q == SettleLast);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_button_i) state_d = StGen;
      StGen:    if (map_ready_i) state_d = StWait;
      StWait:   if (mid_button_i) state_d = StSettle;
      StSettle: if (settled) state_d = StCheck;
      StCheck: begin
        if (lose) begin
          state_d = StLose;
        end else if (win) begin
          state_d = StWin;
        end else begin
          state_d = StWait;
        end
      end
      StWin:    if (start_button_i) state_d = StGen;
      StLose:   if (start_button_i) state_d = StGen;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    screen_state_o = GAME_START;
    busy_o         = 1'b0;
    mid_button_o   = 1'b0;
    timer_run      = 1'b0;
    timer_clr      = 1'b0;
    unique case (state_q)
      StIdle, StGen: begin
        screen_state_o = GAME_START;
        timer_clr      = 1'b1;
      end
      StWait: begin
        screen_state_o = GAME_PLAY;
        mid_button_o   = mid_button_i;
        timer_run      = 1'b1;
      end
      StSettle, StCheck: begin
        screen_state_o = GAME_PLAY;
        busy_o         = 1'b1;
        timer_run      = 1'b1;
      end
      StWin:   screen_state_o = GAME_VICTORY;
      StLose:  screen_state_o = GAME_FAIL;
      default: screen_state_o = GAME_START;
    endcase
  end

  // Reveal history and settle tracking; the counter never passes SettleLast in SETTLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shown_q      <= '0;
      eq_prev_q    <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      shown_q <= map_shown_i;
      if (state_q == StWait && mid_button_i) begin
        eq_prev_q    <= 1'b0;
        settle_cnt_q <= '0;
      end else if (state_q == StSettle) begin
        eq_prev_q    <= shown_eq;
        settle_cnt_q <= settle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 8'(MINE_NUM);
    end else begin
      flags_q <= 8'(MINE_NUM) - 8'(popcount(map_flag_i));
    end
  end

  // Seconds run during play, clear before a game and hold once it is decided.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else if (timer_clr) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else if (timer_run) begin
      if (presc_q == PscLast) begin
        presc_q <= '0;
        if (sec_q != SecMax) begin
          sec_q <= sec_q + 10'd1;
        end
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign flags_left_o = flags_q;
  assign time_sec_o   = sec_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: per-cycle expectations are queued with the stimulus
// and drained against the DUT outputs mid-cycle.
module tb_game_flow_ctrl;

  localparam logic [2:0] GAME_START   = 3'd0;
  localparam logic [2:0] GAME_PLAY    = 3'd1;
  localparam logic [2:0] GAME_VICTORY = 3'd2;
  localparam logic [2:0] GAME_FAIL    = 3'd3;
  localparam int unsigned ClkPerSec   = 4;

  logic         clk;
  logic         rst_n;
  logic         start_button;
  logic         mid_button;
  logic         map_ready;
  logic [255:0] map;
  logic [63:0]  map_shown;
  logic [63:0]  map_flag;
  logic [2:0]   screen_state;
  logic         mid_button_out;
  logic         busy;
  logic [7:0]   flags_left;
  logic [9:0]   time_sec;

  game_flow_ctrl #(
    .CLK_PER_SEC(ClkPerSec)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_button_i(start_button),
    .mid_button_i  (mid_button),
    .map_ready_i   (map_ready),
    .map_i         (map),
    .map_shown_i   (map_shown),
    .map_flag_i    (map_flag),
    .screen_state_o(screen_state),
    .mid_button_o  (mid_button_out),
    .busy_o        (busy),
    .flags_left_o  (flags_left),
    .time_sec_o    (time_sec)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  logic        arm;
  logic [7:0]  flags_m;
  int          sec_m;
  int          presc_m;
  logic [63:0] safe_mask;
  logic [63:0] va;
  logic [63:0] vb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] out_val(input int sel);
    case (sel)
      0:       return 32'(screen_state);
      1:       return 32'(busy);
      2:       return 32'(mid_button_out);
      3:       return 32'(flags_left);
      default: return 32'(time_sec);
    endcase
  endfunction

  // One clock cycle: queue expectations for this cycle, compare, then advance the model.
  task automatic step(input logic [2:0] scr, input logic bsy, input logic mo);
    exp_t e;
    if (arm) begin
      sb.push_back('{tag: "screen", sel: 0, exp: 32'(scr)});
      sb.push_back('{tag: "busy", sel: 1, exp: 32'(bsy)});
      sb.push_back('{tag: "mid_out", sel: 2, exp: 32'(mo)});
      sb.push_back('{tag: "flags_left", sel: 3, exp: 32'(flags_m)});
      sb.push_back('{tag: "time_sec", sel: 4, exp: 32'(sec_m)});
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, out_val(e.sel), e.exp);
    end
    if (!rst_n) begin
      flags_m = 8'd10;
      sec_m   = 0;
      presc_m = 0;
    end else begin
      flags_m = 8'd10 - 8'($countones(map_flag));
      if (scr == GAME_PLAY) begin
        if (presc_m == ClkPerSec - 1) begin
          presc_m = 0;
          if (sec_m < 999) sec_m++;
        end else begin
          presc_m++;
        end
      end else if (scr == GAME_START) begin
        presc_m = 0;
        sec_m   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    arm = 1'b0;
    rst_n = 1'b0;
    start_button = 1'b0;
    mid_button = 1'b0;
    map_ready = 1'b0;
    map_shown = '0;
    map_flag = '0;
    flags_m = 8'd10;
    sec_m = 0;
    presc_m = 0;
    for (int i = 0; i < 64; i++) begin
      map[i*4 +: 4] = (i < 10) ? 4'hF : 4'h1;
    end
    safe_mask = ~64'h3FF;

    // Reset values.
    step(GAME_START, 1'b0, 1'b0);
    arm = 1'b1;
    step(GAME_START, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(GAME_START, 1'b0, 1'b0);

    // Start; a press in GEN is dropped; ready one cycle later.
    start_button = 1'b1; step(GAME_START, 1'b0, 1'b0); start_button = 1'b0;
    mid_button = 1'b1; map_ready = 1'b1; step(GAME_START, 1'b0, 1'b0); mid_button = 1'b0;
    step(GAME_PLAY, 1'b0, 1'b0);
    start_button = 1'b1; step(GAME_PLAY, 1'b0, 1'b0); start_button = 1'b0;
    step(GAME_PLAY, 1'b0, 1'b0);

    // Over-flagging goes negative one cycle later.
    map_flag = 64'hFFF;
    step(GAME_PLAY, 1'b0, 1'b0);
    step(GAME_PLAY, 1'b0, 1'b0);
    check_eq("flags_neg", 32'(flags_left), 32'hFE);
    map_flag = '0;
    step(GAME_PLAY, 1'b0, 1'b0);

    // Press with reveal changing 5 cycles then stable: busy for 5 + 2 + 1 cycles.
    mid_button = 1'b1; step(GAME_PLAY, 1'b0, 1'b1); mid_button = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      map_shown = map_shown | (64'h1 << (10 + k));
      mid_button = (k == 3);
      step(GAME_PLAY, 1'b1, 1'b0);
      mid_button = 1'b0;
    end
    step(GAME_PLAY, 1'b1, 1'b0);
    step(GAME_PLAY, 1'b1, 1'b0);
    step(GAME_PLAY, 1'b1, 1'b0);
    step(GAME_PLAY, 1'b0, 1'b0);
    step(GAME_PLAY, 1'b0, 1'b0);

    // Reveal toggling every cycle: settle timeout after 64 cycles.
    va = map_shown;
    vb = map_shown | (64'h1 << 20);
    mid_button = 1'b1; step(GAME_PLAY, 1'b0, 1'b1); mid_button = 1'b0;
    for (int k = 0; k < 64; k++) begin
      map_shown = (k % 2 == 0) ? vb : va;
      step(GAME_PLAY, 1'b1, 1'b0);
    end
    map_shown = va;
    step(GAME_PLAY, 1'b1, 1'b0);
    step(GAME_PLAY, 1'b0, 1'b0);

    // All 54 safe cells revealed: victory; presses ignored; restart.
    mid_button = 1'b1; step(GAME_PLAY, 1'b0, 1'b1); mid_button = 1'b0;
    map_shown = safe_mask;
    repeat (4) step(GAME_PLAY, 1'b1, 1'b0);
    step(GAME_VICTORY, 1'b0, 1'b0);
    mid_button = 1'b1; step(GAME_VICTORY, 1'b0, 1'b0); mid_button = 1'b0;
    repeat (3) step(GAME_VICTORY, 1'b0, 1'b0);
    start_button = 1'b1; step(GAME_VICTORY, 1'b0, 1'b0); start_button = 1'b0;
    map_shown = '0;
    step(GAME_START, 1'b0, 1'b0);
    step(GAME_PLAY, 1'b0, 1'b0);
    step(GAME_PLAY, 1'b0, 1'b0);

    // Same vector plus a mine: fail wins the tie; timer frozen; restart waits for the map.
    mid_button = 1'b1; step(GAME_PLAY, 1'b0, 1'b1); mid_button = 1'b0;
    map_shown = safe_mask | 64'h1;
    repeat (4) step(GAME_PLAY, 1'b1, 1'b0);
    step(GAME_FAIL, 1'b0, 1'b0);
    mid_button = 1'b1; step(GAME_FAIL, 1'b0, 1'b0); mid_button = 1'b0;
    repeat (5) step(GAME_FAIL, 1'b0, 1'b0);
    start_button = 1'b1; step(GAME_FAIL, 1'b0, 1'b0); start_button = 1'b0;
    map_shown = '0;
    map_ready = 1'b0;
    step(GAME_START, 1'b0, 1'b0);
    step(GAME_START, 1'b0, 1'b0);
    map_ready = 1'b1;
    step(GAME_START, 1'b0, 1'b0);
    repeat (3) step(GAME_PLAY, 1'b0, 1'b0);

    // Reset asserted mid-SETTLE.
    map_flag = 64'hFFF;
    mid_button = 1'b1; step(GAME_PLAY, 1'b0, 1'b1); mid_button = 1'b0;
    map_shown = 64'h1 << 12;
    step(GAME_PLAY, 1'b1, 1'b0);
    rst_n = 1'b0;
    map_shown = 64'h3 << 12;
    step(GAME_PLAY, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(GAME_START, 1'b0, 1'b0);
    map_flag = '0;
    step(GAME_START, 1'b0, 1'b0);
    step(GAME_START, 1'b0, 1'b0);

    // Long game: seconds saturate at 999.
    map_shown = '0;
    start_button = 1'b1; step(GAME_START, 1'b0, 1'b0); start_button = 1'b0;
    step(GAME_START, 1'b0, 1'b0);
    repeat (4100) step(GAME_PLAY, 1'b0, 1'b0);
    check_eq("time_sat", 32'(time_sec), 32'd999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
